// File: rtl/sram_req_arbiter_pkg.sv
// Shared constants and helpers for the two-requester SRAM bus arbiter.
// Requester ids, access size encodings and the default outstanding depth.
package sram_req_arbiter_pkg;

  localparam logic REQ_ID_INST = 1'b0;
  localparam logic REQ_ID_DATA = 1'b1;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  localparam int OST_DEPTH_DEF = 4;

  typedef struct packed {
    logic       wr;
    logic [1:0] size;
    logic [3:0] wstrb;
  } req_ctl_t;

  // Round-robin pick: on a tie the requester that was not granted last wins.
  function automatic logic rr_pick(input logic m0_req, input logic m1_req,
                                   input logic last_gnt);
    if (m0_req && m1_req) return ~last_gnt;
    else if (m1_req)      return REQ_ID_DATA;
    else                  return REQ_ID_INST;
  endfunction

endpackage

// File: rtl/sram_req_arbiter_arb_id_fifo.sv
// In-order FIFO of 1-bit requester ids for accepted, not yet answered requests.
// Same-cycle push and pop are both performed; head is readable combinationally.
module sram_req_arbiter_arb_id_fifo
  import sram_req_arbiter_pkg::*;
#(
  parameter int DEPTH = OST_DEPTH_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic push_id,
  input  logic pop,
  output logic full,
  output logic empty,
  output logic head_id
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] CNT_FULL = (PW + 1)'(DEPTH);

  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PW:0]   count_reg, count_next;
  logic          id_mem_reg [DEPTH];
  logic          do_push, do_pop;

  assign full    = (count_reg == CNT_FULL);
  assign empty   = (count_reg == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head_id = id_mem_reg[rd_ptr_reg];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      // Slots are cleared on reset so the head never reads back as X.
      always_ff @(posedge clk) begin
        if (reset)
          id_mem_reg[gi] <= 1'b0;
        else if (do_push && (wr_ptr_reg == PW'(gi)))
          id_mem_reg[gi] <= push_id;
      end
    end
  endgenerate

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (do_push) wr_ptr_next = wr_ptr_reg + PW'(1);
    if (do_pop)  rd_ptr_next = rd_ptr_reg + PW'(1);
    case ({do_push, do_pop})
      2'b10:   count_next = count_reg + (PW + 1)'(1);
      2'b01:   count_next = count_reg - (PW + 1)'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

endmodule

// File: rtl/sram_req_arbiter.sv
// Two-port SRAM-like bus arbiter (m1 data path over m0 fetch) with in-order response routing.
// Define SRAM_ARB_RR_EN to replace fixed priority with round-robin on ties.
module sram_req_arbiter
  import sram_req_arbiter_pkg::*;
#(
  parameter int OST_DEPTH = OST_DEPTH_DEF,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic [1:0]        m0_size,
  input  logic [3:0]        m0_wstrb,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_addr_ok,
  output logic              m0_data_ok,
  output logic [DATA_W-1:0] m0_rdata,

  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic [1:0]        m1_size,
  input  logic [3:0]        m1_wstrb,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_addr_ok,
  output logic              m1_data_ok,
  output logic [DATA_W-1:0] m1_rdata,

  output logic              s_req,
  output logic              s_wr,
  output logic [1:0]        s_size,
  output logic [3:0]        s_wstrb,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  input  logic              s_addr_ok,
  input  logic              s_data_ok,
  input  logic [DATA_W-1:0] s_rdata
);

  logic              lock_reg, lock_next;
  logic              lock_id_reg, lock_id_next;
  logic              cur_id;
  logic              accept;
  logic              pop;
  logic              fifo_full, fifo_empty, head_id;
  logic [1:0]        addr_ok_vec, data_ok_vec;

  req_ctl_t          ctl_arr  [2];
  logic [ADDR_W-1:0] addr_arr [2];
  logic [DATA_W-1:0] wdata_arr[2];
  req_ctl_t          cur_ctl;

  assign ctl_arr[0]   = '{wr: m0_wr, size: m0_size, wstrb: m0_wstrb};
  assign ctl_arr[1]   = '{wr: m1_wr, size: m1_size, wstrb: m1_wstrb};
  assign addr_arr[0]  = m0_addr;
  assign addr_arr[1]  = m1_addr;
  assign wdata_arr[0] = m0_wdata;
  assign wdata_arr[1] = m1_wdata;

`ifdef SRAM_ARB_RR_EN
  logic last_gnt_reg, last_gnt_next;

  always_comb begin
    last_gnt_next = last_gnt_reg;
    if (accept) last_gnt_next = cur_id;
  end

  always_ff @(posedge clk) begin
    if (reset) last_gnt_reg <= 1'b0;
    else       last_gnt_reg <= last_gnt_next;
  end

  always_comb begin
    cur_id = rr_pick(m0_req, m1_req, last_gnt_reg);
    if (lock_reg) cur_id = lock_id_reg;
  end
`else
  always_comb begin
    cur_id = m1_req ? REQ_ID_DATA : REQ_ID_INST;
    if (lock_reg) cur_id = lock_id_reg;
  end
`endif

  // A full order FIFO blocks the bus even if a response drains it this cycle.
  assign s_req   = ~reset & (lock_reg | m0_req | m1_req) & ~fifo_full;
  assign cur_ctl = ctl_arr[cur_id];
  assign s_wr    = cur_ctl.wr;
  assign s_size  = cur_ctl.size;
  assign s_wstrb = cur_ctl.wstrb;
  assign s_addr  = addr_arr[cur_id];
  assign s_wdata = wdata_arr[cur_id];

  assign accept  = s_req & s_addr_ok;
  assign pop     = ~reset & s_data_ok & ~fifo_empty;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_route
      assign addr_ok_vec[gi] = accept & (cur_id == 1'(gi));
      assign data_ok_vec[gi] = pop & (head_id == 1'(gi));
    end
  endgenerate

  assign m0_addr_ok = addr_ok_vec[0];
  assign m1_addr_ok = addr_ok_vec[1];
  assign m0_data_ok = data_ok_vec[0];
  assign m1_data_ok = data_ok_vec[1];
  assign m0_rdata   = s_rdata;
  assign m1_rdata   = s_rdata;

  // The lock pins the presented requester until the bus accepts it.
  always_comb begin
    lock_next    = lock_reg;
    lock_id_next = lock_id_reg;
    if (s_req) begin
      lock_next = ~s_addr_ok;
      if (!s_addr_ok) lock_id_next = cur_id;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_reg    <= 1'b0;
      lock_id_reg <= 1'b0;
    end else begin
      lock_reg    <= lock_next;
      lock_id_reg <= lock_id_next;
    end
  end

  sram_req_arbiter_arb_id_fifo #(
    .DEPTH(OST_DEPTH)
  ) u_id_fifo (
    .clk    (clk),
    .reset  (reset),
    .push   (accept),
    .push_id(cur_id),
    .pop    (pop),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .head_id(head_id)
  );

endmodule
